// File: rtl/game2048_pkg.sv
`default_nettype none
// ============================================================================
// game2048_pkg : shared tile constants, spawner states, LFSR taps -- rev 1.0
// ============================================================================
package game2048_pkg;

  localparam logic [11:0] TILE_EMPTY = 12'h000;
  localparam logic [11:0] TILE_2     = 12'h002;
  localparam logic [11:0] TILE_4     = 12'h004;

  // x^16 + x^14 + x^13 + x^11 + 1, shift-left Fibonacci form
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    SCAN  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } spawn_state_t;

endpackage
`default_nettype wire

// File: rtl/tile_spawner_if.sv
`default_nettype none
// ============================================================================
// tile_spawner_if : request/board bus between move logic and spawner -- rev 1.0
// ============================================================================
interface tile_spawner_if #(
  parameter int N      = 4,
  parameter int TILE_W = 12
);
  localparam int CNT_W = $clog2(N*N+1);

  logic                             start;
  logic                             init;
  logic [N-1:0][N-1:0][TILE_W-1:0]  board_in;
  logic [N-1:0][N-1:0][TILE_W-1:0]  board_out;
  logic                             done;
  logic                             busy;
  logic                             full;
  logic [CNT_W-1:0]                 tiles_placed;

  modport master (
    output start, init, board_in,
    input  board_out, done, busy, full, tiles_placed
  );

  modport slave (
    input  start, init, board_in,
    output board_out, done, busy, full, tiles_placed
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// lfsr_gen : free-running Fibonacci LFSR, advances every cycle -- rev 1.0
// ============================================================================
module lfsr_gen #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);
  import game2048_pkg::*;

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

  logic fb;
  assign fb = ^(q & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {q[LFSR_W-2:0], fb};
  end
endmodule
`default_nettype wire

// File: rtl/tile_spawner.sv
`default_nettype none
// ============================================================================
// tile_spawner : places 1 or INIT_TILES random 2/4 tiles on empty cells -- rev 1.0
// ============================================================================
module tile_spawner #(
  parameter int                N           = 4,
  parameter int                TILE_W      = 12,
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] SEED        = LFSR_W'(16'hACE1),
  parameter int                FOUR_THRESH = 2,
  parameter int                INIT_TILES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  tile_spawner_if.slave   bus
);
  import game2048_pkg::*;

  localparam int CELLS = N*N;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = $clog2(CELLS+1);

  logic [LFSR_W-1:0]              lfsr_q;
  logic                           lfsr_unused;
  spawn_state_t                   state, state_nx;
  logic [CELLS-1:0][TILE_W-1:0]   board_reg;
  logic [IDX_W-1:0]               idx, idx_nx, lfsr_idx, scan_idx;
  logic [IDX_W-1:0]               scan_cnt, scan_cnt_nx;
  logic [CNT_W-1:0]               placed, placed_nx, target, target_nx;
  logic                           full_r, full_nx;
  logic                           accept, write_en;
  logic [TILE_W-1:0]              new_tile;

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q;
  assign lfsr_idx    = lfsr_q[IDX_W-1:0];
  // Cell count is a power of two, so the increment wraps from the last cell to 0
  assign scan_idx    = idx + IDX_W'(1);
  assign new_tile    = ({1'b0, lfsr_q[3:0]} < 5'(FOUR_THRESH)) ? TILE_W'(TILE_4)
                                                                : TILE_W'(TILE_2);
  assign accept      = (state == IDLE) && bus.start;

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    scan_cnt_nx = scan_cnt;
    placed_nx   = placed;
    target_nx   = target;
    full_nx     = full_r;
    write_en    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx  = PICK;
          idx_nx    = lfsr_idx;
          placed_nx = '0;
          full_nx   = 1'b0;
          target_nx = bus.init ? CNT_W'(INIT_TILES) : CNT_W'(1);
        end
      end
      PICK: begin
        if (board_reg[idx] == TILE_W'(TILE_EMPTY)) begin
          state_nx = WRITE;
        end else begin
          scan_cnt_nx = '0;
          state_nx    = SCAN;
        end
      end
      SCAN: begin
        idx_nx      = scan_idx;
        scan_cnt_nx = scan_cnt + IDX_W'(1);
        if (board_reg[scan_idx] == TILE_W'(TILE_EMPTY)) begin
          state_nx = WRITE;
        end else if (scan_cnt_nx == IDX_W'(CELLS-1)) begin
          full_nx  = 1'b1;
          state_nx = DONE;
        end
      end
      WRITE: begin
        write_en  = 1'b1;
        placed_nx = placed + CNT_W'(1);
        if (placed_nx == target) begin
          state_nx = DONE;
        end else begin
          idx_nx   = lfsr_idx;
          state_nx = PICK;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      scan_cnt  <= '0;
      placed    <= '0;
      target    <= '0;
      full_r    <= 1'b0;
      board_reg <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      scan_cnt <= scan_cnt_nx;
      placed   <= placed_nx;
      target   <= target_nx;
      full_r   <= full_nx;
      if (accept)        board_reg      <= bus.board_in;
      else if (write_en) board_reg[idx] <= new_tile;
    end
  end

  assign bus.board_out    = board_reg;
  assign bus.done         = (state == DONE);
  assign bus.busy         = (state != IDLE);
  assign bus.full         = full_r;
  assign bus.tiles_placed = placed;
endmodule
`default_nettype wire

// File: tb/tb_tile_spawner.sv
`default_nettype none
// ============================================================================
// tb_tile_spawner : randomized bench with a cycle-level placement model -- rev 1.0
// ============================================================================
module tb_tile_spawner;
  localparam int N           = 4;
  localparam int TILE_W      = 12;
  localparam int LFSR_W      = 16;
  localparam int FOUR_THRESH = 2;
  localparam int INIT_TILES  = 2;
  localparam int CELLS       = N*N;

  typedef logic [CELLS-1:0][TILE_W-1:0] board_t;

  logic clk;
  logic rst;
  logic [15:0] m_lfsr;
  int   checks;
  int   errors;
  int   lfsr_zero;
  int   last_edges;
  int   fours;
  int   done_seen;

  tile_spawner_if #(.N(N), .TILE_W(TILE_W)) bus ();

  tile_spawner #(
    .N           (N),
    .TILE_W      (TILE_W),
    .LFSR_W      (LFSR_W),
    .SEED        (16'hACE1),
    .FOUR_THRESH (FOUR_THRESH),
    .INIT_TILES  (INIT_TILES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Reference sequence: same polynomial, same seed, stepped once per clock
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  always @(negedge clk) begin
    if (!rst && dut.lfsr_q == '0) lfsr_zero++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per tile: pick cell = lfsr mod CELLS in the cycle the pick is armed, walk forward
  // d cells to the first empty one (1 cycle each), write 2 cycles + d later using that
  // cycle's LFSR for the 2/4 choice; the write cycle also arms the next pick.
  task automatic predict(input board_t b, input bit ini, input logic [15:0] v0,
                         output board_t eb, output int ep, output bit ef, output int ed);
    int target, t, d, c;
    logic [15:0] v;
    bit found;
    eb = b; ep = 0; ef = 0; ed = 0; t = 0; v = v0; c = 0;
    target = ini ? INIT_TILES : 1;
    while (ep < target && !ef) begin
      found = 0; d = 0;
      while (!found && d < CELLS) begin
        c = (int'(v) % CELLS + d) % CELLS;
        if (eb[c] == '0) found = 1;
        else d++;
      end
      if (!found) begin
        ef = 1;
        ed = t + CELLS + 1;
      end else begin
        for (int k = 0; k < d + 2; k++) v = lfsr_next(v);
        t = t + d + 2;
        eb[c] = (int'(v % 16) < FOUR_THRESH) ? TILE_W'(4) : TILE_W'(2);
        ep++;
      end
    end
    if (!ef) ed = t + 1;
  endtask

  task automatic run_op(input board_t b, input bit ini, input bit poke);
    board_t eb, got;
    int ep, ed, edges, bad, changed;
    bit ef;
    @(negedge clk);
    bus.board_in = b;
    bus.init     = ini;
    bus.start    = 1'b1;
    predict(b, ini, m_lfsr, eb, ep, ef, ed);
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges = 1;
    check("busy_after_accept", bus.busy, 1'b1);
    if (poke) begin
      bus.board_in = ~b;
      bus.init     = ~ini;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      edges++;
    end
    while (!bus.done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    last_edges = edges;
    got = bus.board_out;
    check("latency", edges, ed);
    check("board_out", got, eb);
    check("tiles_placed", bus.tiles_placed, ep);
    check("full", bus.full, ef);
    bad = 0; changed = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (got[i] != b[i]) changed++;
      if (b[i] != '0 && got[i] != b[i]) bad++;
      if (b[i] == '0 && got[i] != '0 && got[i] != TILE_W'(2) && got[i] != TILE_W'(4)) bad++;
      if (b[i] == '0 && got[i] == TILE_W'(4)) fours++;
    end
    check("only_empty_written", bad, 0);
    check("written_count", changed, ep);
    @(posedge clk); #1;
    check("done_one_cycle", {bus.busy, bus.done}, 2'b00);
  endtask

  function automatic board_t rand_board();
    board_t b;
    int dens;
    dens = $urandom_range(0, CELLS);
    for (int i = 0; i < CELLS; i++)
      b[i] = ($urandom_range(0, CELLS-1) < dens) ? '0 : TILE_W'(2) << $urandom_range(0, 9);
    return b;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    board_t b;
    checks = 0; errors = 0; lfsr_zero = 0; fours = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.init = 1'b0; bus.board_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_board_out", bus.board_out, '0);
    check("rst_done", bus.done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_full", bus.full, 1'b0);
    check("rst_tiles_placed", bus.tiles_placed, 0);

    // full board: 1 + 1 + 15 + 1 cycles
    for (int i = 0; i < CELLS; i++) b[i] = TILE_W'(2);
    run_op(b, 1'b0, 1'b0);
    check("full_board_cycles", last_edges + 1, 18);
    check("full_board_flag", bus.full, 1'b1);

    // single empty cell at [2][1]
    for (int i = 0; i < CELLS; i++) b[i] = TILE_W'(8);
    b[2*N+1] = '0;
    run_op(b, 1'b0, 1'b0);
    check("single_empty_lat_le19", (last_edges + 1) <= 19, 1'b1);

    // empty board, new game
    b = '0;
    run_op(b, 1'b1, 1'b0);
    check("init_two_tiles", bus.tiles_placed, 2);

    // one empty, new game: runs out after one tile
    for (int i = 0; i < CELLS; i++) b[i] = TILE_W'(16);
    b[$urandom_range(0, CELLS-1)] = '0;
    run_op(b, 1'b1, 1'b0);
    check("init_one_empty_full", {bus.full, bus.tiles_placed}, {1'b1, 5'd1});

    // reset while scanning a full board
    for (int i = 0; i < CELLS; i++) b[i] = TILE_W'(2);
    @(negedge clk);
    bus.board_in = b; bus.init = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_board_out", bus.board_out, '0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // start pulsed while busy must be ignored
    b = rand_board();
    b[0] = '0;
    run_op(b, 1'b0, 1'b1);
    done_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("no_second_done", done_seen, 0);

    // random boards, random mode
    repeat (200) run_op(rand_board(), 1'(($urandom_range(0, 1))), 1'b0);

    // 1000 single spawns on boards with 15 empty cells
    fours = 0;
    repeat (1000) begin
      b = '0;
      b[$urandom_range(0, CELLS-1)] = TILE_W'(8);
      run_op(b, 1'b0, 1'b0);
    end
    check("four_ratio_in_80_170", (fours >= 80) && (fours <= 170), 1'b1);
    check("lfsr_never_zero", lfsr_zero, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
